// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, res;
    logic [OPW-1:0]   op_ctrl;
    logic             owner, last_grant, zf, err;
    logic             grant0, grant1, op_legal;

    assign op_legal = (op_ctrl == OPW'(4'b0010)) || (op_ctrl == OPW'(4'b0110)) ||
                      (op_ctrl == OPW'(4'b0000)) || (op_ctrl == OPW'(4'b0001));

    // Grants are gated by reset so no handshake is seen as accepted while the block is being cleared.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (req0_valid && (!req1_valid || last_grant))
                        grant0 = 1'b1;
                    else if (req1_valid)
                        grant1 = 1'b1;
                end
                if (grant0 || grant1)
                    state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (owner ? rsp1_ready : rsp0_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_ctrl    <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            res        <= '0;
            zf         <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant0 || grant1) begin
                op_a       <= grant1 ? req1_a  : req0_a;
                op_b       <= grant1 ? req1_b  : req0_b;
                op_ctrl    <= grant1 ? req1_op : req0_op;
                owner      <= grant1;
                last_grant <= grant1;
            end
            if (state == EXEC) begin
                res <= alu_result;
                zf  <= alu_zero;
                err <= !op_legal;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign rsp_result = res;
    assign rsp_zero   = zf;
    assign rsp_err    = err;
    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_ctrl   = op_ctrl;
    assign busy       = (state != IDLE);

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

- Shares the single 32-bit ALU (ops: ADD 4'b0010, SUB 4'b0110, AND 4'b0000, OR 4'b0001) between two requesters, e.g. the main datapath and the branch/address unit.
- Each requester uses a valid/ready request handshake and a valid/ready response handshake.
- The block arbitrates round-robin, registers operands, drives the ALU, captures result and zero flag, and holds the response until it is accepted.
- Sits between the requesters and the ALU instance; the ALU stays purely combinational.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- OPW, 4, ALU control width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_op  in  OPW  requester 0 ALU control code
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- rsp0_valid  out  1  response for requester 0 is valid
- rsp0_ready  in  1  requester 0 takes the response
- rsp1_valid  out  1  response for requester 1 is valid
- rsp1_ready  in  1  requester 1 takes the response
- rsp_result  out  WIDTH  shared response data, qualified by rsp0_valid/rsp1_valid
- rsp_zero  out  1  registered ALU zero flag
- rsp_err  out  1  op code was not one of the four legal codes
- alu_a, alu_b  out  WIDTH  to ALU A/B
- alu_ctrl  out  OPW  to ALU control
- alu_result  in  WIDTH  from ALU
- alu_zero  in  1  from ALU
- busy  out  1  state != IDLE

## Operation
FSM states:
- **IDLE**
  - Arbitrate: if exactly one reqN_valid, grant N. If both, grant the requester that is not last_grant.
  - Grant means reqN_ready=1 combinationally in this cycle (valid&ready = accept).
  - On accept: op_a/op_b/op_ctrl <= reqN fields, owner <= N, last_grant <= N, go to EXEC.
  - The non-granted requester gets ready=0.
- **EXEC**
  - alu_a/alu_b/alu_ctrl = op_a/op_b/op_ctrl (they always are).
  - Capture: res <= alu_result, zf <= alu_zero, err <= (op_ctrl not in {0010,0110,0000,0001}). Go to RESP.
- **RESP**
  - rsp{owner}_valid=1; the other rsp valid stays 0. rsp_result=res, rsp_zero=zf, rsp_err=err.
  - Hold all values stable until rsp{owner}_ready=1, then go to IDLE.
- Illegal op: no special path. ALU yields 0, so rsp_result=0, rsp_zero=1, rsp_err=1.
- Result width: result is the ALU's WIDTH bits. Overflow and carry are not reported; the subtraction wrap (e.g. 0-1 = 32'hFFFF_FFFF) is passed through.
- reqN_ready is 0 in every state except IDLE. No new request is accepted while a response is pending.
- Inputs reqN_* only need to be stable in the accept cycle.

## Timing
- Accept in cycle T → rsp valid from cycle T+2, with the response handshake completing no earlier than cycle T+2.
- If rsp_ready=1 at T+2, the block is in IDLE at T+3 and can accept again at T+3. Peak throughput is 1 op per 3 cycles.
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - op_a/op_b/op_ctrl=0, so alu_a/alu_b/alu_ctrl=0.
  - res=0, zf=0, err=0, owner=0.
  - All ready/valid outputs 0, busy=0.
- Reset in EXEC or RESP: the pending operation and response are discarded with no rsp_valid pulse. The next cycle is IDLE with reset values.
- Requester dropping valid: a requester dropping reqN_valid before accept is legal; it is simply not granted.
- Response backpressure: rsp_ready held low indefinitely keeps RESP with outputs frozen. Other requesters wait (ready=0).
- rsp_ready asserted while the corresponding rsp_valid=0 is ignored.

## Test plan
- **Reset**: assert reset 2 cycles mid-EXEC → next cycle busy=0, all valids/readies 0, alu_ctrl=0, and no rsp pulse afterwards.
- **Single ADD**: req0 A=5, B=7, op=0010 at T → req0_ready=1 at T; rsp0_valid=1 at T+2 with result=12, zero=0, err=0; rsp1_valid=0 throughout.
- **SUB wrap and zero**: req1 A=0, B=1, op=0110 → result=32'hFFFF_FFFF, zero=0. Then A=9, B=9, SUB → result=0, zero=1.
- **Round-robin**: both valid continuously with rsp_ready=1, req0 AND (F0F0_F0F0 & FF00_FF00), req1 OR (0000_000F | 0000_00F0) → grants alternate 0,1,0,1. Results F000_F000 and 0000_00FF appear on the correct rspN_valid.
- **Backpressure**: rsp0_ready=0 for 5 cycles → rsp0_valid and data stable, req1_ready=0 the whole time. Raise rsp0_ready → IDLE next cycle, then req1 is accepted.
- **Illegal op**: op=4'b1111, A=3, B=4 → rsp_result=0, rsp_zero=1, rsp_err=1.
